// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply sequencer: ALU control codes
// and the sequencer FSM state encoding.
package mul_seq_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_XOR  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_ADD  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_MUL  = 4'b0101;
    localparam logic [3:0] ALU_ADDI = 4'b0110;
    localparam logic [3:0] ALU_SRAI = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul_seq_ctrl_step_dp.sv
// One shift-add multiply iteration: retires STEP_BITS multiplier bits into the
// accumulator and shifts the operands for the next iteration.
module mul_step_dp #(
    parameter int STEP_BITS = 1
) (
    input  logic [31:0] acc_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic [31:0] acc_o,
    output logic [31:0] mcand_o,
    output logic [31:0] mplier_o
);

    logic [31:0] digit;
    logic [31:0] partial;

    // Partial product is truncated to 32 bits; only the low word is ever needed.
    assign digit    = {{(32-STEP_BITS){1'b0}}, mplier_i[STEP_BITS-1:0]};
    assign partial  = mcand_i * digit;
    assign acc_o    = acc_i + partial;
    assign mcand_o  = mcand_i << STEP_BITS;
    assign mplier_o = mplier_i >> STEP_BITS;

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer for the EX stage with stall/valid/ready handshake.
// Optional early-out on a zero remaining multiplier: define MUL_EARLY_OUT_EN.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int         STEP_BITS = 1,
    parameter logic [3:0] MUL_CODE  = ALU_MUL
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  alu_ctrl_i,
    input  logic [31:0] data1_i,
    input  logic [31:0] data2_i,
    input  logic        flush_i,
    input  logic        ready_i,
    output logic        stall_o,
    output logic        valid_o,
    output logic [31:0] data_o,
    output logic        busy_o
);

    localparam logic [5:0] N_CNT = 6'(32 / STEP_BITS);

    state_e      state_q;
    logic [31:0] acc_q, mcand_q, mplier_q, data_q;
    logic [31:0] acc_d, mcand_d, mplier_d;
    logic [5:0]  cnt_q;
    logic        valid_q;
    logic        start_mul, accept, early_in, early_busy;

    mul_step_dp #(.STEP_BITS(STEP_BITS)) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (acc_d),
        .mcand_o  (mcand_d),
        .mplier_o (mplier_d)
    );

    assign start_mul = start_i & (alu_ctrl_i == MUL_CODE);
    assign accept    = start_mul & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & ready_i));

`ifdef MUL_EARLY_OUT_EN
    assign early_in   = (data2_i == 32'd0);
    assign early_busy = (mplier_d == 32'd0);
`else
    assign early_in   = 1'b0;
    assign early_busy = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BUSY: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_d;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q - 6'd1;
                    if ((cnt_q == 6'd1) || early_busy) begin
                        state_q <= ST_DONE;
                        data_q  <= acc_d;
                        valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ready_i) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                ST_IDLE: ;
                default: state_q <= ST_IDLE;
            endcase
            // Issue overrides the DONE->IDLE exit so back-to-back ops skip the idle bubble.
            if (accept) begin
                acc_q    <= '0;
                mcand_q  <= data1_i;
                mplier_q <= data2_i;
                cnt_q    <= N_CNT;
                if (early_in) begin
                    state_q <= ST_DONE;
                    data_q  <= '0;
                    valid_q <= 1'b1;
                end else begin
                    state_q <= ST_BUSY;
                    valid_q <= 1'b0;
                end
            end
        end
    end

    assign stall_o = rst_i & ~flush_i &
                     (((state_q == ST_IDLE) & start_mul) |
                      (state_q == ST_BUSY) |
                      ((state_q == ST_DONE) & ~ready_i));
    assign busy_o  = (state_q == ST_BUSY);
    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: vector table, random products against a
// plain-arithmetic model, and hand-written flush/reset/back-to-back sequences.
module tb_mul_seq_ctrl;

    localparam logic [3:0] MUL = 4'b0101;
    localparam logic [3:0] ADD = 4'b0011;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i, flush_i, ready_i;
    logic [3:0]  alu_ctrl_i;
    logic [31:0] data1_i, data2_i;
    logic        stall_o, valid_o, busy_o;
    logic [31:0] data_o;

    logic        s4_start, s4_ready;
    logic [3:0]  s4_alu;
    logic [31:0] s4_d1, s4_d2;
    logic        s4_stall, s4_valid, s4_busy, s4_flush;
    logic [31:0] s4_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_seq_ctrl #(.STEP_BITS(1)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .alu_ctrl_i(alu_ctrl_i),
        .data1_i(data1_i), .data2_i(data2_i), .flush_i(flush_i), .ready_i(ready_i),
        .stall_o(stall_o), .valid_o(valid_o), .data_o(data_o), .busy_o(busy_o)
    );

    mul_seq_ctrl #(.STEP_BITS(4)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .start_i(s4_start), .alu_ctrl_i(s4_alu),
        .data1_i(s4_d1), .data2_i(s4_d2), .flush_i(s4_flush), .ready_i(s4_ready),
        .stall_o(s4_stall), .valid_o(s4_valid), .data_o(s4_data), .busy_o(s4_busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges after the accepting edge until valid_o is seen.
    function automatic int exp_lat(input logic [31:0] b, input int sb);
`ifdef MUL_EARLY_OUT_EN
        int bits = 0;
        if (b == 32'd0) return 0;
        for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
        return (bits + sb - 1) / sb;
`else
        return 32 / sb;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return p[31:0];
    endfunction

    task automatic wait_valid(input string nm, input int exp_l);
        int lat = 0;
        while (valid_o !== 1'b1 && lat < 200) begin
            step();
            lat++;
        end
        check({nm, "_latency"}, lat, exp_l);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start_i = 1'b1; alu_ctrl_i = MUL; data1_i = a; data2_i = b;
        #1;
        check("stall_on_issue", {31'd0, stall_o}, 32'd1);
        step();
        start_i = 1'b0; data1_i = $urandom; data2_i = $urandom;
    endtask

    task automatic release_result(input string nm);
        #1;
        check({nm, "_stall_done"}, {31'd0, stall_o}, 32'd1);
        ready_i = 1'b1;
        #1;
        check({nm, "_stall_ready"}, {31'd0, stall_o}, 32'd0);
        step();
        ready_i = 1'b0;
        check({nm, "_valid_after"}, {31'd0, valid_o}, 32'd0);
        check({nm, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        issue(a, b);
        wait_valid(nm, exp_lat(b, 1));
        check({nm, "_data"}, data_o, exp);
        release_result(nm);
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back('{32'd7,        32'd6,        32'd42,         "7x6"});
        vecs.push_back('{32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,   "neg3x5"});
        vecs.push_back('{32'h80000000, 32'd2,        32'h00000000,   "wrap"});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001,   "m1xm1"});
        vecs.push_back('{32'd5,        32'd0,        32'd0,          "5x0"});
        vecs.push_back('{32'h12345678, 32'h10,       32'h23456780,   "shift4"});

        rst_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        start_i = 1'b1; alu_ctrl_i = MUL; data1_i = 32'd1; data2_i = 32'd1;
        s4_start = 1'b0; s4_ready = 1'b0; s4_alu = MUL; s4_d1 = '0; s4_d2 = '0; s4_flush = 1'b0;
        step(); step();
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_data", data_o, 32'd0);
        start_i = 1'b0;
        rst_i = 1'b1;
        step();

        // Non-MUL code is ignored.
        start_i = 1'b1; alu_ctrl_i = ADD; data1_i = 32'd3; data2_i = 32'd4;
        #1;
        check("add_stall", {31'd0, stall_o}, 32'd0);
        step();
        start_i = 1'b0;
        check("add_busy", {31'd0, busy_o}, 32'd0);
        check("add_valid", {31'd0, valid_o}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].nm);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? ($urandom & 32'hFF) : $urandom;
            run_op(a, b, model(a, b), "rand");
        end

        // Flush at BUSY cycle 10: result discarded, next op unaffected.
        issue(32'd1234, 32'd5678);
        repeat (9) step();
        check("flush_pre_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_o}, 32'd0);
        step();
        flush_i = 1'b0;
        check("flush_busy", {31'd0, busy_o}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (valid_o) seen++;
                step();
            end
            check("flush_no_valid", seen, 0);
        end
        run_op(32'd3, 32'd4, 32'd12, "post_flush");

        // Async reset mid-operation clears outputs without waiting for an edge.
        issue(32'd77, 32'hFFFF0000);
        repeat (4) step();
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy_o}, 32'd0);
        check("midrst_stall", {31'd0, stall_o}, 32'd0);
        check("midrst_valid", {31'd0, valid_o}, 32'd0);
        check("midrst_data", data_o, 32'd0);
        step();
        rst_i = 1'b1;
        step();

        // Back-to-back: hold result 3 DONE cycles, then accept with a new issue.
        issue(32'd7, 32'd6);
        wait_valid("b2b_first", exp_lat(32'd6, 1));
        for (int i = 0; i < 3; i++) begin
            check("b2b_hold_data", data_o, 32'd42);
            check("b2b_hold_stall", {31'd0, stall_o}, 32'd1);
            check("b2b_hold_valid", {31'd0, valid_o}, 32'd1);
            if (i < 2) step();
        end
        ready_i = 1'b1; start_i = 1'b1; alu_ctrl_i = MUL; data1_i = 32'd9; data2_i = 32'd9;
        step();
        ready_i = 1'b0; start_i = 1'b0; data1_i = $urandom; data2_i = $urandom;
        check("b2b_busy", {31'd0, busy_o}, 32'd1);
        check("b2b_valid_low", {31'd0, valid_o}, 32'd0);
        wait_valid("b2b_second", exp_lat(32'd9, 1));
        check("b2b_data", data_o, 32'd81);
        release_result("b2b");

        // STEP_BITS = 4 instance.
        s4_start = 1'b1; s4_d1 = 32'h12345678; s4_d2 = 32'h10;
        step();
        s4_start = 1'b0; s4_d1 = $urandom; s4_d2 = $urandom;
        begin
            int lat = 0;
            while (s4_valid !== 1'b1 && lat < 200) begin
                step();
                lat++;
            end
            check("sb4_latency", lat, exp_lat(32'h10, 4));
        end
        check("sb4_data", s4_data, 32'h23456780);
        s4_ready = 1'b1;
        step();
        s4_ready = 1'b0;
        check("sb4_valid_after", {31'd0, s4_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the MUL operation of the EX stage, replacing the single-cycle 32x32 multiply path.
- Latches operands when the ALU control code is MUL and runs an iterative shift-add multiply, STEP_BITS multiplier bits per cycle.
- Stalls the pipeline until the consumer accepts the result.
- Produces the low 32 bits of the product, which are identical for signed and unsigned operands.

Parameters:
- STEP_BITS, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8.
- MUL_CODE, 4'b0101, ALU control code that triggers a multiply.

Ports:
- clk_i  in  1  clock; rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  EX stage presents an operation this cycle.
- alu_ctrl_i  in  4  ALU control code of the presented operation.
- data1_i  in  32  multiplicand.
- data2_i  in  32  multiplier.
- flush_i  in  1  abort any operation in flight.
- ready_i  in  1  consumer accepts data_o this cycle.
- stall_o  out  1  pipeline hold request.
- valid_o  out  1  data_o holds a finished product.
- data_o  out  32  low 32 bits of data1_i*data2_i.
- busy_o  out  1  FSM is in BUSY.

Behaviour:
- Definitions: N = 32/STEP_BITS. start_mul = start_i & (alu_ctrl_i == MUL_CODE).
- Reset (rst_i = 0, any time, async): state = IDLE; acc, mcand, mplier, cnt cleared; valid_o = 0, data_o = 0, busy_o = 0. stall_o = 0 while reset is held.
- IDLE:
  - start_mul: latch mcand = data1_i, mplier = data2_i, acc = 0, cnt = N; go to BUSY.
  - start_i with a non-MUL code: ignored; stays IDLE; stall_o = 0.
- BUSY, each edge:
  - acc += mcand * mplier[STEP_BITS-1:0], truncated to 32 bits.
  - mcand <<= STEP_BITS; mplier >>= STEP_BITS (logical); cnt -= 1.
  - When cnt == 1 at the edge: go to DONE and register the final acc into data_o.
- DONE: valid_o = 1 and data_o is held stable.
  - ready_i = 1: go to IDLE.
  - ready_i = 1 and start_mul in the same cycle: latch the new operands and go directly to BUSY (back-to-back issue, no idle bubble).
- Latency: start_mul is sampled at edge E0. valid_o is high after edge E(N), i.e. N+1 cycles including the issue cycle. For STEP_BITS = 1, valid_o rises 32 edges after acceptance.
- stall_o (combinational) = (IDLE & start_mul) | BUSY | (DONE & ~ready_i).
- busy_o = (state == BUSY).
- flush_i, any state:
  - Next state is IDLE; valid_o = 0 next cycle; result discarded.
  - flush_i has priority over start_i and ready_i in the same cycle.
  - stall_o is forced to 0 in the flush cycle.
- Arithmetic: all accumulation is modulo 2^32; overflow is silently discarded. Operand sign needs no special handling.
- Operand inputs are don't-care outside the accepting cycle.

Optional Feature:
- Macro: MUL_EARLY_OUT_EN.
- Defined:
  - In BUSY, if the post-shift mplier == 0 at an edge, go to DONE at that edge regardless of cnt.
  - In IDLE, if data2_i == 0 on start_mul, go straight to DONE with data_o = 0 (latency 1).
  - Multiplying by 0 therefore yields valid_o after 1 edge.
  - Multiplying by 6 with STEP_BITS = 1 yields valid_o after 3 edges.
- Undefined: fixed N-cycle latency; no zero-detect logic.

Decomposition:
- Shared package:
  - ALU control code constants (AND, XOR, SLL, ADD, SUB, MUL, ADDI, SRAI), currently 4-bit defines local to the ALU.
  - FSM state encoding: IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2.
- Sub-module mul_step_dp: combinational partial-product-and-shift unit.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, next mcand, next mplier.
  - Parameterised by STEP_BITS.
- The FSM, counter and handshake stay in mul_seq_ctrl.

Test Plan:
- STEP_BITS = 1: start_mul with 7, 6 → stall_o high, valid_o after 32 edges, data_o = 42. ready_i = 1 → IDLE and stall_o = 0 next cycle.
- Signed operands: -3 (0xFFFFFFFD) * 5 → data_o = 0xFFFFFFF1. Wrap case: 0x80000000 * 2 → data_o = 0x00000000.
- start_i with alu_ctrl_i = 4'b0011 (ADD) → no state change, stall_o = 0, valid_o stays 0.
- Mid-operation events:
  - flush_i at BUSY cycle 10 → IDLE next edge; valid_o never rises; a following 3*4 gives 12.
  - rst_i low at BUSY cycle 5 → outputs 0 immediately.
- Back-to-back: hold ready_i = 0 for 3 DONE cycles (data_o stable, stall_o = 1), then ready_i = 1 with start_mul(9, 9) → BUSY, no bubble, second data_o = 81.
- STEP_BITS = 4, 0x12345678 * 0x10 → valid_o after 8 edges, data_o = 0x23456780. With MUL_EARLY_OUT_EN, 5 * 0 → valid_o after 1 edge, data_o = 0.
